ifid_stage_reg: RTL
===================

Name: ifid_stage_reg

Overview:
- Pipeline register between Fetch and Decode.
- Latches the fetched instruction and PC+2, and holds them when the hazard detector raises stall.
- Squashes to a NOP bubble on a branch/jump flush or when I-memory has no valid data.
- Freezes the PC once a HALT is latched.
- Drives the PC write enable and exposes stall counters for debug and performance work.

Parameters:
- INSTR_W, 16, instruction width.
- PC_W, 16, PC width.
- CNT_W, 16, width of the stall performance counter.
- STALL_LIMIT, 64, number of consecutive stall cycles at which stall_timeout asserts.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- if_instr  in  INSTR_W  instruction from I-memory.
- if_pc2  in  PC_W  PC+2 of if_instr.
- if_valid  in  1  I-memory data valid this cycle.
- stall  in  1  RAW stall from the hazard detector (ORed over ID/EX and EX/MEM comparisons).
- flush  in  1  branch/jump redirect; squashes the younger wrong-path instruction.
- ifid_instr  out  INSTR_W  instruction presented to Decode.
- ifid_pc2  out  PC_W  PC+2 presented to Decode.
- ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
- pc_en  out  1  PC register write enable (combinational).
- ifid_halted  out  1  HALT has been latched; fetch is frozen.
- stall_cycles  out  CNT_W  saturating count of stall-hold cycles.
- stall_timeout  out  1  consecutive stall count has reached STALL_LIMIT.

Behaviour:
- All register updates occur on posedge clk. Reset is synchronous only, active-high.
- Reset values:
  - ifid_instr = NOP_INSTR (16'h0800, opcode 00001).
  - ifid_pc2 = 0, ifid_valid = 0, ifid_halted = 0.
  - stall_cycles = 0, consecutive counter = 0, stall_timeout = 0.
  - state = RUN.
- FSM states:
  - RUN: normal fetch.
  - HOLD: register frozen by stall.
  - HALT: HALT latched, fetch frozen.
- Per-cycle priority: rst > flush > stall > (!if_valid) > load.
- flush, in any state:
  - Register loads NOP_INSTR, ifid_valid = 0, ifid_pc2 = 0.
  - Next state RUN; ifid_halted clears.
  - pc_en = 1 so the redirect target is written.
  - Flush with stall in the same cycle: flush wins.
- RUN or HOLD with stall and no flush:
  - All outputs held; next state HOLD; pc_en = 0.
  - stall_cycles increments, saturating at all-ones.
  - Consecutive counter increments, saturating at STALL_LIMIT.
- RUN or HOLD with no stall and no flush:
  - Consecutive counter clears. pc_en = if_valid.
  - If !if_valid: load NOP_INSTR with ifid_valid = 0 (memory bubble); next state RUN.
  - Else: load if_instr and if_pc2 with ifid_valid = 1.
    - If if_instr[15:11] == OP_HALT (00000): next state HALT and ifid_halted = 1 from the next cycle.
    - Otherwise next state RUN.
- HALT without flush:
  - pc_en = 0 and ifid_halted = 1.
  - The HALT instruction stays presented exactly one cycle. From the cycle after it was presented, the register holds NOP_INSTR with ifid_valid = 0.
  - stall is ignored: no counter increment.
- stall_timeout is combinational: (consecutive count == STALL_LIMIT). It is not sticky.
- HALT latched on a wrong path is undone by a later flush, which returns the FSM to RUN.
- Latency: an accepted instruction appears on ifid_* exactly 1 cycle after it is presented on if_*.

Decomposition:
- Shared package/include wisc_pkg:
  - OP_HALT = 5'b00000, OP_NOP = 5'b00001.
  - NOP_INSTR = 16'h0800.
  - FSM state encoding: RUN = 2'd0, HOLD = 2'd1, HALT = 2'd2.
- One sub-module, sat_counter (parameterised width and limit, with inc, clr and rst inputs). It is instantiated twice: once for stall_cycles and once for the consecutive stall count.

Test Plan:
- Reset: rst high for 2 cycles with if_valid=1, if_instr=16'h4123 -> ifid_instr=16'h0800, ifid_valid=0, ifid_pc2=0, stall_cycles=0, pc_en reflects RUN.
- Normal load: if_instr=16'hD8A4, if_pc2=16'h0002, if_valid=1 -> next cycle ifid_instr=16'hD8A4, ifid_pc2=16'h0002, ifid_valid=1, pc_en=1.
- Stall hold: after loading 16'h8A20, raise stall for 3 cycles -> ifid_instr stays 16'h8A20, pc_en=0 for those 3 cycles, stall_cycles=3; drop stall -> new instruction loads and the consecutive count clears.
- Flush beats stall: assert stall and flush together -> ifid_instr=16'h0800, ifid_valid=0, pc_en=1, state RUN, stall_cycles unchanged.
- HALT sequence: load 16'h0000 -> HALT shown for 1 cycle with valid=1, then ifid_halted=1, pc_en=0, ifid_valid=0 while fetch keeps presenting instructions; a flush then returns to RUN with ifid_halted=0.
- Timeout/saturation: STALL_LIMIT=4, hold stall for 6 cycles -> stall_timeout rises on the 5th cycle (count==4) and stays high; drop stall -> stall_timeout=0 the next cycle.
- Memory bubble: if_valid=0 for 2 cycles -> ifid_valid=0, ifid_instr=16'h0800, pc_en=0 during those cycles.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared ISA constants and IF/ID stage state encoding.
package wisc_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HALT = 5'b00000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00001;

  localparam logic [15:0] NOP_INSTR = {OP_NOP, 11'd0};

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and reset.
module sat_counter #(
  parameter int unsigned W     = 16,
  parameter int unsigned LIMIT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != W'(LIMIT))) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ifid_stage_reg.sv
// IF/ID pipeline register: stall hold, flush/bubble squash, HALT freeze,
// PC write enable and stall performance counters.
module ifid_stage_reg
  import wisc_pkg::*;
#(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned PC_W        = 16,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic [PC_W-1:0]    if_pc2,
  input  logic               if_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc2,
  output logic               ifid_valid,
  output logic               pc_en,
  output logic               ifid_halted,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               stall_timeout
);

  localparam int unsigned CC_W      = $clog2(STALL_LIMIT + 1);
  localparam int unsigned CNT_LIMIT = 32'((64'd1 << CNT_W) - 64'd1);

  localparam logic [INSTR_W-1:0] NOP_W = INSTR_W'(NOP_INSTR);

  ifid_state_e        state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc2_q, pc2_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               stall_inc;
  logic               cons_clr;
  logic [CC_W-1:0]    cons_cnt;

  // Next-state and register-load selection: flush > stall > bubble > load.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc2_d     = pc2_q;
    valid_d   = valid_q;
    halted_d  = halted_q;
    pc_en     = 1'b0;
    stall_inc = 1'b0;
    cons_clr  = 1'b1;

    if (flush) begin
      state_d  = ST_RUN;
      instr_d  = NOP_W;
      pc2_d    = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      pc_en    = 1'b1;
    end else begin
      case (state_q)
        ST_HALT: begin
          instr_d  = NOP_W;
          valid_d  = 1'b0;
          halted_d = 1'b1;
        end
        default: begin
          if (stall) begin
            state_d   = ST_HOLD;
            stall_inc = 1'b1;
            cons_clr  = 1'b0;
          end else begin
            pc_en = if_valid;
            if (!if_valid) begin
              state_d = ST_RUN;
              instr_d = NOP_W;
              valid_d = 1'b0;
            end else begin
              instr_d = if_instr;
              pc2_d   = if_pc2;
              valid_d = 1'b1;
              if (if_instr[INSTR_W-1 -: OPC_W] == OP_HALT) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
              end else begin
                state_d  = ST_RUN;
                halted_d = 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      instr_q  <= NOP_W;
      pc2_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      pc2_q    <= pc2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  // Lifetime stall-hold count; never cleared except by reset.
  sat_counter #(
    .W     (CNT_W),
    .LIMIT (CNT_LIMIT)
  ) u_stall_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_cycles)
  );

  // Consecutive stall-hold count; any non-hold cycle clears it.
  sat_counter #(
    .W     (CC_W),
    .LIMIT (STALL_LIMIT)
  ) u_cons_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clr   (cons_clr),
    .count (cons_cnt)
  );

  assign stall_timeout = (cons_cnt == CC_W'(STALL_LIMIT));

  assign ifid_instr  = instr_q;
  assign ifid_pc2    = pc2_q;
  assign ifid_valid  = valid_q;
  assign ifid_halted = halted_q;

endmodule
